// File: rtl/xc_pmul_seq_if.sv
// Operand/result handshake bundle for xc_pmul_seq. The master supplies packed
// operands and consumes results; the slave is the sequential multiplier.
interface xc_pmul_seq_if;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] rs1;
  logic [31:0] rs2;
  logic        pw_32;
  logic        pw_16;
  logic        pw_8;
  logic        pw_4;
  logic        pw_2;
  logic        high;
  logic        carryless;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] result;
  logic        busy;

  modport master (
    output flush, in_valid, rs1, rs2, pw_32, pw_16, pw_8, pw_4, pw_2,
           high, carryless, out_ready,
    input  in_ready, out_valid, result, busy
  );

  modport slave (
    input  flush, in_valid, rs1, rs2, pw_32, pw_16, pw_8, pw_4, pw_2,
           high, carryless, out_ready,
    output in_ready, out_valid, result, busy
  );
endinterface

// File: rtl/xc_pmul_seq.sv
// Sequential packed-SIMD multiplier: shift-and-add (or GF(2) shift-and-xor) over
// W-bit elements, RADIX multiplier bits per element per cycle, 2W-bit product slots.
module xc_pmul_seq #(
  parameter int RADIX = 1
) (
  input  logic         g_clk,
  input  logic         g_reset,
  xc_pmul_seq_if.slave bus
);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_e;

  state_e      state_q,  state_d;
  logic [31:0] mc_q,     mc_d;
  logic [31:0] mul_q,    mul_d;
  logic [63:0] acc_q,    acc_d;
  logic [5:0]  cnt_q,    cnt_d;
  logic [4:0]  width_q,  width_d;
  logic        high_q,   high_d;
  logic        clmul_q,  clmul_d;
  logic        busy_q,   busy_d;
  logic [31:0] result_q, result_d;

  logic [4:0]       pw_in;
  logic             in_ready;
  logic             accept;
  logic [5:0]       cnt_load;
  logic [4:0][63:0] acc_step;
  logic [4:0][31:0] mul_step;
  logic [63:0]      acc_next;
  logic [31:0]      mul_next;

  // Bit k of a width vector selects element width 2<<k.
  assign pw_in = {bus.pw_32, bus.pw_16, bus.pw_8, bus.pw_4, bus.pw_2};

  assign in_ready      = !bus.flush && (state_q == IDLE || (state_q == DONE && bus.out_ready));
  assign accept        = bus.in_valid && in_ready;
  assign bus.in_ready  = in_ready;
  assign bus.out_valid = (state_q == DONE) && !bus.flush;
  assign bus.busy      = busy_q;
  assign bus.result    = result_q;

  // One iteration for every candidate width; the registered width picks one.
  for (genvar k = 0; k < 5; k++) begin : g_width
    localparam int W  = 2 << k;
    localparam int W2 = 2 * W;
    for (genvar i = 0; i < 32 / W; i++) begin : g_elem
      logic [W-1:0]       mc;
      logic [W+RADIX-1:0] hi_ext;
      logic [W+RADIX-1:0] pp0;
      logic [W+RADIX-1:0] pp1;
      logic [W+RADIX-1:0] sum;
      logic               b0;
      logic               b1;

      assign mc     = mc_q[W*i +: W];
      assign b0     = mul_q[W*i];
      assign b1     = (RADIX == 2) ? mul_q[W*i+1] : 1'b0;
      assign hi_ext = {{RADIX{1'b0}}, acc_q[W2*i+W +: W]};
      assign pp0    = b0 ? {{RADIX{1'b0}}, mc} : '0;
      assign pp1    = b1 ? ({{RADIX{1'b0}}, mc} << 1) : '0;
      // Upper half plus partial products fits in W+RADIX bits, so the slot never carries out.
      assign sum    = clmul_q ? (hi_ext ^ pp0 ^ pp1) : (hi_ext + pp0 + pp1);

      assign acc_step[k][W2*i +: W2] = W2'({sum, acc_q[W2*i +: W]} >> RADIX);
      assign mul_step[k][W*i +: W]   = mul_q[W*i +: W] >> RADIX;
    end
  end

  function automatic logic [31:0] extract(input logic [63:0] acc,
                                          input logic [4:0]  width,
                                          input logic        hi);
    logic [31:0] r;
    logic [5:0]  src;
    int          ew;
    r = '0;
    for (int k = 0; k < 5; k++) begin
      if (width[k]) begin
        ew = 2 << k;
        for (int b = 0; b < 32; b++) begin
          src  = 6'(((b >> (k + 1)) << (k + 2)) + (hi ? ew : 0) + (b & (ew - 1)));
          r[b] = acc[src];
        end
      end
    end
    return r;
  endfunction

  always_comb begin
    cnt_load = '0;
    acc_next = '0;
    mul_next = '0;
    for (int k = 0; k < 5; k++) begin
      if (pw_in[k])   cnt_load = 6'((2 << k) / RADIX);
      if (width_q[k]) begin
        acc_next = acc_step[k];
        mul_next = mul_step[k];
      end
    end
  end

  always_comb begin
    // NOTE: every _d starts from its _q so no branch below can leave a latch behind.
    state_d = state_q;
    mc_d    = mc_q;
    mul_d   = mul_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    width_d = width_q;
    high_d  = high_q;
    clmul_d = clmul_q;

    unique case (state_q)
      IDLE: ;
      BUSY: begin
        acc_d = acc_next;
        mul_d = mul_next;
        cnt_d = cnt_q - 6'd1;
        if (cnt_q == 6'd1) state_d = DONE;
      end
      DONE: if (bus.out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // Acceptance only happens from IDLE or a draining DONE, so it may override the above.
    if (accept) begin
      mc_d    = bus.rs1;
      mul_d   = bus.rs2;
      acc_d   = '0;
      high_d  = bus.high;
      clmul_d = bus.carryless;
      if ($onehot(pw_in)) begin
        width_d = pw_in;
        cnt_d   = cnt_load;
        state_d = BUSY;
      end else begin
        width_d = '0;
        cnt_d   = '0;
        state_d = DONE;
      end
    end

    if (bus.flush) begin
      state_d = IDLE;
      mc_d    = '0;
      mul_d   = '0;
      acc_d   = '0;
      cnt_d   = '0;
      width_d = '0;
    end

    busy_d   = (state_d != IDLE);
    result_d = (state_d == DONE) ? extract(acc_d, width_d, high_d) : '0;
  end

  always_ff @(posedge g_clk) begin
    // NOTE: non-blocking assignments so every flop samples the pre-edge values.
    if (g_reset) begin
      state_q  <= IDLE;
      mc_q     <= '0;
      mul_q    <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
      width_q  <= '0;
      high_q   <= 1'b0;
      clmul_q  <= 1'b0;
      busy_q   <= 1'b0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      mc_q     <= mc_d;
      mul_q    <= mul_d;
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
      width_q  <= width_d;
      high_q   <= high_d;
      clmul_q  <= clmul_d;
      busy_q   <= busy_d;
      result_q <= result_d;
    end
  end

endmodule
